// File: rtl/apuf_eval_ctrl_if.sv
// Request/response bundle between the host command logic and the arbiter PUF
// evaluation controller. The host side uses the master modport, the controller
// uses the slave modport.
interface apuf_eval_ctrl_if #(
    parameter int CHAL_W = 8,
    parameter int VOTES  = 5
);
    logic                         Req_valid;
    logic                         Req_ready;
    logic [CHAL_W-1:0]            Req_chal;
    logic                         Resp_valid;
    logic                         Resp_ready;
    logic                         Resp;
    logic [$clog2(VOTES+1)-1:0]   Resp_conf;
    logic                         Resp_timeout;

    modport master (
        output Req_valid, Req_chal, Resp_ready,
        input  Req_ready, Resp_valid, Resp, Resp_conf, Resp_timeout
    );

    modport slave (
        input  Req_valid, Req_chal, Resp_ready,
        output Req_ready, Resp_valid, Resp, Resp_conf, Resp_timeout
    );
endinterface

// File: rtl/apuf_eval_ctrl.sv
// Evaluation controller for an arbiter PUF. Takes a challenge, runs the delay
// chain VOTES times (clear arbiter, launch pulse, wait for done, record bit)
// and returns the majority bit, the number of ones and a timeout flag.
module apuf_eval_ctrl #(
    parameter int CHAL_W      = 8,
    parameter int VOTES       = 5,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    apuf_eval_ctrl_if.slave   bus,
    output logic [CHAL_W-1:0] Challenge,
    output logic              Pulse,
    output logic              ArbReset,
    input  logic              ArbResult,
    input  logic              ArbDone
);
    localparam int CONF_W = $clog2(VOTES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FIRE,
        RECORD,
        RESP
    } state_t;

    state_t              state;
    logic                res_m, res_s, done_m, done_s;
    logic [CHAL_W-1:0]   challenge_q;
    logic                pulse_q;
    logic                arb_reset_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_q;
    logic [CONF_W-1:0]   resp_conf_q;
    logic                resp_timeout_q;
    logic [CONF_W-1:0]   ones_cnt;
    logic [CONF_W-1:0]   evals_cnt;
    logic [CONF_W-1:0]   ones_next;
    logic [SET_W-1:0]    settle_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                res_cap;

    assign ones_next = ones_cnt + CONF_W'(res_cap);

    assign bus.Req_ready    = req_ready_q & ~Reset;
    assign bus.Resp_valid   = resp_valid_q;
    assign bus.Resp         = resp_q;
    assign bus.Resp_conf    = resp_conf_q;
    assign bus.Resp_timeout = resp_timeout_q;
    assign Challenge        = challenge_q;
    assign Pulse            = pulse_q;
    assign ArbReset         = arb_reset_q | Reset;

    // Bring the asynchronous arbiter result and done into the clock domain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_m  <= 1'b0;
            res_s  <= 1'b0;
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            res_m  <= ArbResult;
            res_s  <= res_m;
            done_m <= ArbDone;
            done_s <= done_m;
        end
    end

    // Evaluation sequencer: clear, fire, record per vote, then hold the response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            challenge_q    <= '0;
            pulse_q        <= 1'b0;
            arb_reset_q    <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_q         <= 1'b0;
            resp_conf_q    <= '0;
            resp_timeout_q <= 1'b0;
            ones_cnt       <= '0;
            evals_cnt      <= '0;
            settle_cnt     <= '0;
            wait_cnt       <= '0;
            res_cap        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req_valid && req_ready_q) begin
                        challenge_q    <= bus.Req_chal;
                        ones_cnt       <= '0;
                        evals_cnt      <= '0;
                        settle_cnt     <= '0;
                        arb_reset_q    <= 1'b1;
                        req_ready_q    <= 1'b0;
                        resp_q         <= 1'b0;
                        resp_conf_q    <= '0;
                        resp_timeout_q <= 1'b0;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        arb_reset_q <= 1'b0;
                        pulse_q     <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= FIRE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                FIRE: begin
                    if (done_s) begin
                        res_cap <= res_s;
                        pulse_q <= 1'b0;
                        state   <= RECORD;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        pulse_q        <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        resp_q         <= 1'b0;
                        resp_conf_q    <= ones_cnt;
                        resp_timeout_q <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RECORD: begin
                    ones_cnt  <= ones_next;
                    evals_cnt <= evals_cnt + CONF_W'(1);
                    if (evals_cnt != CONF_W'(VOTES - 1)) begin
                        settle_cnt  <= '0;
                        arb_reset_q <= 1'b1;
                        state       <= CLEAR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_q       <= (ones_next > CONF_W'(VOTES / 2));
                        resp_conf_q  <= ones_next;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.Resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for the arbiter PUF evaluation controller. A behavioural
// arbiter raises done a programmable number of cycles after Pulse rises and
// returns a per-evaluation result bit from a pattern.
module tb_apuf_eval_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;

    logic        use_b = 1'b0;
    logic        req_valid_drv = 1'b0;
    logic [7:0]  req_chal_drv = 8'h00;
    logic        resp_ready_drv = 1'b0;

    int          done_delay = 3;
    logic [15:0] result_pat = '0;
    int          hang_eval = -1;
    int          eval_idx = 0;
    int          pulse_cnt = 0;
    logic        model_done = 1'b0;
    logic        model_res = 1'b0;

    int tests = 0;
    int failures = 0;

    logic [7:0] chal_a, chal_b;
    logic       pulse_a, pulse_b, arbrst_a, arbrst_b;

    apuf_eval_ctrl_if #(.CHAL_W(8), .VOTES(5)) bus_a ();
    apuf_eval_ctrl_if #(.CHAL_W(8), .VOTES(1)) bus_b ();

    assign bus_a.Req_valid  = req_valid_drv & ~use_b;
    assign bus_a.Req_chal   = req_chal_drv;
    assign bus_a.Resp_ready = resp_ready_drv & ~use_b;
    assign bus_b.Req_valid  = req_valid_drv & use_b;
    assign bus_b.Req_chal   = req_chal_drv;
    assign bus_b.Resp_ready = resp_ready_drv & use_b;

    apuf_eval_ctrl #(.CHAL_W(8), .VOTES(5), .SETTLE_CYC(4), .TIMEOUT_CYC(16)) dut_a (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus_a.slave),
        .Challenge (chal_a),
        .Pulse     (pulse_a),
        .ArbReset  (arbrst_a),
        .ArbResult (model_res),
        .ArbDone   (model_done & ~use_b)
    );

    apuf_eval_ctrl #(.CHAL_W(8), .VOTES(1), .SETTLE_CYC(4), .TIMEOUT_CYC(16)) dut_b (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus_b.slave),
        .Challenge (chal_b),
        .Pulse     (pulse_b),
        .ArbReset  (arbrst_b),
        .ArbResult (model_res),
        .ArbDone   (model_done & use_b)
    );

    logic       sel_req_ready, sel_resp_valid, sel_resp, sel_timeout, sel_pulse, sel_arbrst;
    logic [3:0] sel_conf;
    logic [7:0] sel_chal;

    assign sel_req_ready  = use_b ? bus_b.Req_ready    : bus_a.Req_ready;
    assign sel_resp_valid = use_b ? bus_b.Resp_valid   : bus_a.Resp_valid;
    assign sel_resp       = use_b ? bus_b.Resp         : bus_a.Resp;
    assign sel_timeout    = use_b ? bus_b.Resp_timeout : bus_a.Resp_timeout;
    assign sel_conf       = use_b ? {3'b000, bus_b.Resp_conf} : {1'b0, bus_a.Resp_conf};
    assign sel_chal       = use_b ? chal_b   : chal_a;
    assign sel_pulse      = use_b ? pulse_b  : pulse_a;
    assign sel_arbrst     = use_b ? arbrst_b : arbrst_a;

    // Free-running clock, 10 time units per cycle.
    always #5 Clk = ~Clk;

    // Arbiter model: done and result appear done_delay cycles into the pulse.
    always @(negedge Clk) begin
        if (sel_pulse) begin
            pulse_cnt = pulse_cnt + 1;
            if (pulse_cnt == done_delay && eval_idx != hang_eval) begin
                model_done = 1'b1;
                model_res  = result_pat[eval_idx];
            end
        end else begin
            if (model_done) eval_idx = eval_idx + 1;
            model_done = 1'b0;
            pulse_cnt  = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests = tests + 1;
        assert (observed === expected)
        else begin
            failures = failures + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Configure the arbiter model, hand a challenge to the selected controller
    // and wait for its response; reports cycles from the accept edge onwards.
    task automatic applyStimulus(input logic sel_b, input logic [7:0] chal,
                                 input logic [15:0] pat, input int delay, input int hang,
                                 output int lat, output logic chal_ok, output logic no_overlap);
        int guard;
        use_b      = sel_b;
        result_pat = pat;
        done_delay = delay;
        hang_eval  = hang;
        eval_idx   = 0;
        chal_ok    = 1'b1;
        no_overlap = 1'b1;
        lat        = 0;
        guard      = 0;
        while (!sel_req_ready && guard < 50) begin
            step(1);
            guard++;
        end
        checkOutput("req_ready_wait", {31'd0, sel_req_ready}, 32'd1);
        req_valid_drv = 1'b1;
        req_chal_drv  = chal;
        step(1);
        req_valid_drv = 1'b0;
        while (!sel_resp_valid && lat < 3000) begin
            if (sel_chal !== chal) chal_ok = 1'b0;
            if (sel_pulse && sel_arbrst) no_overlap = 1'b0;
            if (lat == 7) begin
                req_valid_drv = 1'b1;
                req_chal_drv  = ~chal;
            end else begin
                req_valid_drv = 1'b0;
            end
            step(1);
            lat++;
        end
        req_valid_drv = 1'b0;
        if (sel_chal !== chal) chal_ok = 1'b0;
    endtask

    // Complete the response handshake and confirm the return to idle.
    task automatic finishResp(input string tag);
        resp_ready_drv = 1'b1;
        step(1);
        resp_ready_drv = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'd0, sel_resp_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, sel_req_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        int   guard;
        logic chal_ok, no_ovl, seen;

        // Reset state
        step(1);
        checkOutput("rst_req_ready", {31'd0, bus_a.Req_ready}, 32'd0);
        checkOutput("rst_arbreset", {31'd0, arbrst_a}, 32'd1);
        checkOutput("rst_pulse", {31'd0, pulse_a}, 32'd0);
        checkOutput("rst_challenge", {24'd0, chal_a}, 32'd0);
        step(2);
        Reset = 1'b0;
        step(1);
        checkOutput("post_rst_ready", {31'd0, bus_a.Req_ready}, 32'd1);
        checkOutput("post_rst_arbreset", {31'd0, arbrst_a}, 32'd0);
        checkOutput("post_rst_resp_valid", {31'd0, bus_a.Resp_valid}, 32'd0);

        // Majority of 1,1,0,1,0: F = 3 + 2 sync cycles = 5, 5*(4+5+1) = 50
        applyStimulus(1'b0, 8'hA5, 16'b01011, 3, -1, lat, chal_ok, no_ovl);
        checkOutput("vote_latency", lat, 32'd50);
        checkOutput("vote_resp", {31'd0, sel_resp}, 32'd1);
        checkOutput("vote_conf", {28'd0, sel_conf}, 32'd3);
        checkOutput("vote_timeout", {31'd0, sel_timeout}, 32'd0);
        checkOutput("vote_chal_const", {31'd0, chal_ok}, 32'd1);
        checkOutput("vote_no_overlap", {31'd0, no_ovl}, 32'd1);
        checkOutput("vote_chal", {24'd0, sel_chal}, 32'h0000_00A5);

        // Response held while the consumer stalls
        for (int i = 0; i < 10; i++) begin
            step(1);
            checkOutput("stall_valid", {31'd0, sel_resp_valid}, 32'd1);
            checkOutput("stall_resp", {31'd0, sel_resp}, 32'd1);
            checkOutput("stall_conf", {28'd0, sel_conf}, 32'd3);
        end
        finishResp("vote");

        // Back-to-back minority: 0,1,0,0,1
        applyStimulus(1'b0, 8'h5A, 16'b10010, 3, -1, lat, chal_ok, no_ovl);
        checkOutput("minor_latency", lat, 32'd50);
        checkOutput("minor_resp", {31'd0, sel_resp}, 32'd0);
        checkOutput("minor_conf", {28'd0, sel_conf}, 32'd2);
        checkOutput("minor_chal_const", {31'd0, chal_ok}, 32'd1);
        finishResp("minor");

        // All ones
        applyStimulus(1'b0, 8'hFF, 16'b11111, 3, -1, lat, chal_ok, no_ovl);
        checkOutput("ones_resp", {31'd0, sel_resp}, 32'd1);
        checkOutput("ones_conf", {28'd0, sel_conf}, 32'd5);
        checkOutput("ones_timeout", {31'd0, sel_timeout}, 32'd0);
        finishResp("ones");

        // Timeout on the third evaluation: 2*10 + 4 clear + 16 fire = 40
        applyStimulus(1'b0, 8'h3C, 16'b00011, 3, 2, lat, chal_ok, no_ovl);
        checkOutput("tmo_latency", lat, 32'd40);
        checkOutput("tmo_flag", {31'd0, sel_timeout}, 32'd1);
        checkOutput("tmo_resp", {31'd0, sel_resp}, 32'd0);
        checkOutput("tmo_conf", {28'd0, sel_conf}, 32'd2);
        checkOutput("tmo_pulse", {31'd0, sel_pulse}, 32'd0);
        finishResp("tmo");

        // Reset held three cycles in the middle of FIRE
        use_b         = 1'b0;
        eval_idx      = 0;
        hang_eval     = -1;
        req_valid_drv = 1'b1;
        req_chal_drv  = 8'h77;
        step(1);
        req_valid_drv = 1'b0;
        guard = 0;
        while (!pulse_a && guard < 100) begin
            step(1);
            guard++;
        end
        checkOutput("midfire_reached", {31'd0, pulse_a}, 32'd1);
        step(1);
        Reset = 1'b1;
        step(1);
        checkOutput("midrst_pulse", {31'd0, pulse_a}, 32'd0);
        checkOutput("midrst_arbreset", {31'd0, arbrst_a}, 32'd1);
        checkOutput("midrst_resp_valid", {31'd0, bus_a.Resp_valid}, 32'd0);
        step(2);
        Reset = 1'b0;
        step(1);
        checkOutput("midrst_ready", {31'd0, bus_a.Req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus_a.Resp_valid) seen = 1'b1;
            step(1);
        end
        checkOutput("midrst_no_resp", {31'd0, seen}, 32'd0);

        // VOTES=1, done seen in the last FIRE cycle: 4 + 16 + 1 = 21
        applyStimulus(1'b1, 8'hC3, 16'b1, 14, -1, lat, chal_ok, no_ovl);
        checkOutput("edge_latency", lat, 32'd21);
        checkOutput("edge_timeout", {31'd0, sel_timeout}, 32'd0);
        checkOutput("edge_resp", {31'd0, sel_resp}, 32'd1);
        checkOutput("edge_conf", {28'd0, sel_conf}, 32'd1);
        finishResp("edge");

        // VOTES=1 with a zero result: 4 + 5 + 1 = 10
        applyStimulus(1'b1, 8'h12, 16'b0, 3, -1, lat, chal_ok, no_ovl);
        checkOutput("single_latency", lat, 32'd10);
        checkOutput("single_resp", {31'd0, sel_resp}, 32'd0);
        checkOutput("single_conf", {28'd0, sel_conf}, 32'd0);
        finishResp("single");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
